// File: rtl/decode_stage_pipe_if.sv
// Decode-stage handshake bus: fetch side, write-back port and ID/EX output register.
interface decode_stage_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instruction;
    logic              flush;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [XLEN-1:0]   wb_value;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_data1;
    logic [XLEN-1:0]   out_data2;
    logic [XLEN-1:0]   out_store_data;
    logic [4:0]        out_dest;
    logic [3:0]        out_aluop;
    logic              out_reg_write;
    logic              out_mem_read;
    logic              out_mem_write;
    logic              out_branch;
    logic              out_illegal;
    logic [CNT_W-1:0]  stall_count;

    // Driver of instructions/write-back, consumer of the ID/EX register
    modport master (
        output in_valid, instruction, flush, wb_en, wb_addr, wb_value, out_ready,
        input  in_ready, out_valid, out_data1, out_data2, out_store_data, out_dest,
               out_aluop, out_reg_write, out_mem_read, out_mem_write, out_branch,
               out_illegal, stall_count
    );

    // The decode stage itself
    modport slave (
        input  in_valid, instruction, flush, wb_en, wb_addr, wb_value, out_ready,
        output in_ready, out_valid, out_data1, out_data2, out_store_data, out_dest,
               out_aluop, out_reg_write, out_mem_read, out_mem_write, out_branch,
               out_illegal, stall_count
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// Pipelined MIPS decode stage: register file with write-back bypass, decoder,
// ID/EX output register with load-use bubble insertion, flush and stall counter.
module decode_stage_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    decode_stage_pipe_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NREG);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [5:0]       opcode, func;
    logic [4:0]       rs, rt, rd;
    logic [15:0]      imm;
    logic [XLEN-1:0]  imm_ext;
    logic [IDX_W-1:0] rs_idx, rt_idx, wb_idx;
    logic             wb_hit;

    assign opcode  = bus.instruction[31:26];
    assign rs      = bus.instruction[25:21];
    assign rt      = bus.instruction[20:16];
    assign rd      = bus.instruction[15:11];
    assign func    = bus.instruction[5:0];
    assign imm     = bus.instruction[15:0];
    assign imm_ext = XLEN'($signed(imm));
    assign rs_idx  = rs[IDX_W-1:0];
    assign rt_idx  = rt[IDX_W-1:0];
    assign wb_idx  = bus.wb_addr[IDX_W-1:0];
    assign wb_hit  = bus.wb_en && (wb_idx != '0);

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];
    logic [XLEN-1:0] rs_val, rt_val;

    // Register file write port; entry 0 is never written
    always_comb begin
        rf_d = rf_q;
        if (wb_hit) rf_d[wb_idx] = bus.wb_value;
    end

    // Register file storage
    always_ff @(posedge clk) begin
        if (reset) rf_q <= '{default: '0};
        else       rf_q <= rf_d;
    end

    // Operand reads with same-cycle write-back bypass
    always_comb begin
        rs_val = rf_q[rs_idx];
        rt_val = rf_q[rt_idx];
        if (rs_idx == '0)                     rs_val = '0;
        else if (wb_hit && wb_idx == rs_idx)  rs_val = bus.wb_value;
        if (rt_idx == '0)                     rt_val = '0;
        else if (wb_hit && wb_idx == rt_idx)  rt_val = bus.wb_value;
    end

    logic [3:0]      dec_aluop;
    logic [4:0]      dec_dest;
    logic [XLEN-1:0] dec_data2;
    logic            dec_rw, dec_mr, dec_mw, dec_br, dec_ill, uses_rt;

    // Instruction decode into control fields
    always_comb begin
        dec_aluop = ALU_AND;
        dec_dest  = '0;
        dec_data2 = rt_val;
        dec_rw    = 1'b0;
        dec_mr    = 1'b0;
        dec_mw    = 1'b0;
        dec_br    = 1'b0;
        dec_ill   = 1'b0;
        uses_rt   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                uses_rt  = 1'b1;
                dec_rw   = 1'b1;
                dec_dest = rd;
                case (func)
                    FN_ADD:  dec_aluop = ALU_ADD;
                    FN_SUB:  dec_aluop = ALU_SUB;
                    FN_AND:  dec_aluop = ALU_AND;
                    FN_OR:   dec_aluop = ALU_OR;
                    FN_SLT:  dec_aluop = ALU_SLT;
                    default: begin
                        dec_ill  = 1'b1;
                        dec_rw   = 1'b0;
                        dec_dest = '0;
                    end
                endcase
            end
            OP_ADDI: begin
                dec_aluop = ALU_ADD;
                dec_rw    = 1'b1;
                dec_dest  = rt;
                dec_data2 = imm_ext;
            end
            OP_LW: begin
                dec_aluop = ALU_ADD;
                dec_rw    = 1'b1;
                dec_mr    = 1'b1;
                dec_dest  = rt;
                dec_data2 = imm_ext;
            end
            OP_SW: begin
                uses_rt   = 1'b1;
                dec_aluop = ALU_ADD;
                dec_mw    = 1'b1;
                dec_data2 = imm_ext;
            end
            OP_BEQ: begin
                uses_rt   = 1'b1;
                dec_aluop = ALU_SUB;
                dec_br    = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_dest == '0) dec_rw = 1'b0;
    end

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  data1_q, data1_d, data2_q, data2_d, store_q, store_d;
    logic [4:0]       dest_q, dest_d;
    logic [3:0]       aluop_q, aluop_d;
    logic             rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, br_q, br_d, ill_q, ill_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             load_en, hazard, in_ready_w, accept;

    assign load_en    = !valid_q || bus.out_ready;
    assign hazard     = valid_q && mr_q && (dest_q != '0)
                        && ((dest_q == rs) || (uses_rt && (dest_q == rt)));
    assign in_ready_w = load_en && !hazard && !bus.flush;
    assign accept     = bus.in_valid && in_ready_w;

    // ID/EX register next state: flush, accept, load-use bubble, drain, hold
    always_comb begin
        valid_d = valid_q;
        data1_d = data1_q;
        data2_d = data2_q;
        store_d = store_q;
        dest_d  = dest_q;
        aluop_d = aluop_q;
        rw_d    = rw_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        br_d    = br_q;
        ill_d   = ill_q;
        stall_d = stall_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            data1_d = rs_val;
            data2_d = dec_data2;
            store_d = rt_val;
            dest_d  = dec_dest;
            aluop_d = dec_aluop;
            rw_d    = dec_rw;
            mr_d    = dec_mr;
            mw_d    = dec_mw;
            br_d    = dec_br;
            ill_d   = dec_ill;
        end else if (load_en && hazard) begin
            valid_d = 1'b0;
            if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
        end else if (load_en) begin
            valid_d = 1'b0;
        end
    end

    // ID/EX register and stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
            store_q <= '0;
            dest_q  <= '0;
            aluop_q <= '0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            store_q <= store_d;
            dest_q  <= dest_d;
            aluop_q <= aluop_d;
            rw_q    <= rw_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            br_q    <= br_d;
            ill_q   <= ill_d;
            stall_q <= stall_d;
        end
    end

    assign bus.in_ready       = in_ready_w;
    assign bus.out_valid      = valid_q;
    assign bus.out_data1      = data1_q;
    assign bus.out_data2      = data2_q;
    assign bus.out_store_data = store_q;
    assign bus.out_dest       = dest_q;
    assign bus.out_aluop      = aluop_q;
    assign bus.out_reg_write  = rw_q;
    assign bus.out_mem_read   = mr_q;
    assign bus.out_mem_write  = mw_q;
    assign bus.out_branch     = br_q;
    assign bus.out_illegal    = ill_q;
    assign bus.stall_count    = stall_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Testbench for decode_stage_pipe: directed scenarios plus randomized traffic
// against an instruction-level reference model; a second instance covers NREG=8, XLEN=16.
module tb_decode_stage_pipe;
    logic clk = 1'b0;
    logic reset;
    logic reset8;
    logic rdy_seen;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    decode_stage_pipe_if #(.XLEN(32), .CNT_W(16)) bus ();
    decode_stage_pipe_if #(.XLEN(16), .CNT_W(16)) bus8 ();

    decode_stage_pipe #(.XLEN(32), .NREG(32), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    decode_stage_pipe #(.XLEN(16), .NREG(8), .CNT_W(16)) u_dut8 (
        .clk(clk), .reset(reset8), .bus(bus8)
    );

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] sd;
        logic [4:0]  dest;
        logic [3:0]  aluop;
        logic        rw, mr, mw, br, ill;
    } exp_t;

    logic        m_valid;
    exp_t        m_out;
    logic [31:0] m_regs [32];
    int unsigned m_stall;

    // Count a comparison and report it when it disagrees
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Architectural register read as seen during the current cycle
    function automatic logic [31:0] m_read(input int idx);
        if (idx == 0) return 32'h0;
        if (bus.wb_en && int'(bus.wb_addr) == idx) return bus.wb_value;
        return m_regs[idx];
    endfunction

    // What the ID/EX register should hold after decoding ins
    function automatic exp_t m_decode(input logic [31:0] ins);
        exp_t e;
        logic [5:0] op, fn;
        logic [31:0] imm;
        op  = ins[31:26];
        fn  = ins[5:0];
        imm = {{16{ins[15]}}, ins[15:0]};
        e = '0;
        e.d1 = m_read(int'(ins[25:21]));
        e.sd = m_read(int'(ins[20:16]));
        e.d2 = e.sd;
        if (op == 6'h00) begin
            case (fn)
                6'h20:   e.aluop = 4'b0010;
                6'h22:   e.aluop = 4'b0110;
                6'h24:   e.aluop = 4'b0000;
                6'h25:   e.aluop = 4'b0001;
                6'h2a:   e.aluop = 4'b0111;
                default: e.ill = 1'b1;
            endcase
            if (!e.ill) begin
                e.rw = 1'b1;
                e.dest = ins[15:11];
            end
        end else if (op == 6'h08) begin
            e.aluop = 4'b0010; e.rw = 1'b1; e.dest = ins[20:16]; e.d2 = imm;
        end else if (op == 6'h23) begin
            e.aluop = 4'b0010; e.rw = 1'b1; e.mr = 1'b1; e.dest = ins[20:16]; e.d2 = imm;
        end else if (op == 6'h2b) begin
            e.aluop = 4'b0010; e.mw = 1'b1; e.d2 = imm;
        end else if (op == 6'h04) begin
            e.aluop = 4'b0110; e.br = 1'b1;
        end else begin
            e.ill = 1'b1;
        end
        if (e.dest == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    // Load-use conflict between the held load and the offered instruction
    function automatic logic m_hazard(input logic [31:0] ins);
        logic uses_rt;
        uses_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2b) || (ins[31:26] == 6'h04);
        return m_valid && m_out.mr && (m_out.dest != 5'd0)
               && ((m_out.dest == ins[25:21]) || (uses_rt && (m_out.dest == ins[20:16])));
    endfunction

    task automatic drive(input logic iv, input logic [31:0] ins, input logic fl,
                         input logic we, input logic [4:0] wa, input logic [31:0] wv,
                         input logic ordy);
        bus.in_valid    = iv;
        bus.instruction = ins;
        bus.flush       = fl;
        bus.wb_en       = we;
        bus.wb_addr     = wa;
        bus.wb_value    = wv;
        bus.out_ready   = ordy;
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after
    task automatic step(input string tag, output logic rdy_obs);
        logic load_en, hz, rdy, acc;
        exp_t dec;
        #1;
        load_en = !m_valid || bus.out_ready;
        hz      = m_hazard(bus.instruction);
        rdy     = load_en && !hz && !bus.flush;
        rdy_obs = bus.in_ready;
        check({tag, ".in_ready"}, bus.in_ready, rdy);
        acc = bus.in_valid && rdy;
        dec = m_decode(bus.instruction);
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_out   = '0;
            m_stall = 0;
            foreach (m_regs[k]) m_regs[k] = 32'h0;
        end else begin
            if (bus.wb_en && bus.wb_addr != 5'd0) m_regs[bus.wb_addr] = bus.wb_value;
            if (bus.flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1;
                m_out   = dec;
            end else if (load_en && hz) begin
                m_valid = 1'b0;
                if (m_stall < 65535) m_stall++;
            end else if (load_en) m_valid = 1'b0;
        end
        #1;
        check({tag, ".valid"}, bus.out_valid, m_valid);
        check({tag, ".data1"}, bus.out_data1, m_out.d1);
        check({tag, ".data2"}, bus.out_data2, m_out.d2);
        check({tag, ".store"}, bus.out_store_data, m_out.sd);
        check({tag, ".ctrl"},
              {bus.out_dest, bus.out_aluop, bus.out_reg_write, bus.out_mem_read,
               bus.out_mem_write, bus.out_branch, bus.out_illegal},
              {m_out.dest, m_out.aluop, m_out.rw, m_out.mr, m_out.mw, m_out.br, m_out.ill});
        check({tag, ".stall"}, bus.stall_count, 16'(m_stall));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  op, fn;
        logic [15:0] imm;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        sh  = 5'($urandom);
        imm = 16'($urandom);
        fn  = 6'h20;
        case ($urandom_range(0, 7))
            0, 1: begin
                op = 6'h00;
                case ($urandom_range(0, 5))
                    0:       fn = 6'h20;
                    1:       fn = 6'h22;
                    2:       fn = 6'h24;
                    3:       fn = 6'h25;
                    4:       fn = 6'h2a;
                    default: fn = 6'($urandom);
                endcase
            end
            2:       op = 6'h08;
            3, 4:    op = 6'h23;
            5:       op = 6'h2b;
            6:       op = 6'h04;
            default: op = 6'($urandom);
        endcase
        if (op == 6'h00) return {op, rs, rt, rd, sh, fn};
        return {op, rs, rt, imm};
    endfunction

    initial begin
        m_valid = 1'b0;
        m_out   = '0;
        m_stall = 0;
        foreach (m_regs[k]) m_regs[k] = 32'h0;
        reset  = 1'b1;
        reset8 = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        bus8.in_valid = 1'b0; bus8.instruction = 32'h0; bus8.flush = 1'b0;
        bus8.wb_en = 1'b0; bus8.wb_addr = 5'd0; bus8.wb_value = 16'h0; bus8.out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset state
        step("rst", rdy_seen);
        check("rst.out_valid", bus.out_valid, 1'b0);
        check("rst.stall", bus.stall_count, 16'd0);
        reset = 1'b0;

        // add r3,r1,r2 after writing r1=5, r2=7
        drive(1'b0, 32'h0, 1'b0, 1'b1, 5'd1, 32'd5, 1'b1); step("wb1", rdy_seen);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 5'd2, 32'd7, 1'b1); step("wb2", rdy_seen);
        drive(1'b1, 32'h00221820, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1); step("add", rdy_seen);
        check("add.valid", bus.out_valid, 1'b1);
        check("add.d1", bus.out_data1, 32'd5);
        check("add.d2", bus.out_data2, 32'd7);
        check("add.dest", bus.out_dest, 5'd3);
        check("add.aluop", bus.out_aluop, 4'b0010);
        check("add.rw", bus.out_reg_write, 1'b1);

        // addi r1,r0,5 while write-back targets r0
        drive(1'b1, 32'h20010005, 1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b1); step("addi", rdy_seen);
        check("addi.d1", bus.out_data1, 32'd0);
        check("addi.d2", bus.out_data2, 32'd5);
        check("addi.dest", bus.out_dest, 5'd1);
        drive(1'b1, 32'h00003020, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1); step("r0rd", rdy_seen);
        check("r0rd.d1", bus.out_data1, 32'd0);

        // lw r4,8(r1) followed by dependent add r5,r4,r1
        drive(1'b1, 32'h8C240008, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1); step("lw", rdy_seen);
        check("lw.mr", bus.out_mem_read, 1'b1);
        check("lw.d2", bus.out_data2, 32'd8);
        drive(1'b1, 32'h00812820, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1); step("lu1", rdy_seen);
        check("lu1.in_ready", rdy_seen, 1'b0);
        check("lu1.valid", bus.out_valid, 1'b0);
        check("lu1.stall", bus.stall_count, 16'd1);
        step("lu2", rdy_seen);
        check("lu2.in_ready", rdy_seen, 1'b1);
        check("lu2.dest", bus.out_dest, 5'd5);

        // Backpressure on a held sub r7,r1,r2
        drive(1'b1, 32'h00223822, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1); step("sub", rdy_seen);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00224024, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0); step("hold", rdy_seen);
            check("hold.in_ready", rdy_seen, 1'b0);
            check("hold.aluop", bus.out_aluop, 4'b0110);
            check("hold.dest", bus.out_dest, 5'd7);
        end
        drive(1'b1, 32'h00224024, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1); step("rel", rdy_seen);
        check("rel.dest", bus.out_dest, 5'd8);
        check("rel.aluop", bus.out_aluop, 4'b0000);

        // Flush with a valid output and an offered instruction
        drive(1'b1, 32'h00224825, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1); step("flush", rdy_seen);
        check("flush.in_ready", rdy_seen, 1'b0);
        check("flush.valid", bus.out_valid, 1'b0);

        // Reset mid-stream drops the concurrent write-back
        drive(1'b1, 32'h00225020, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1); step("pre", rdy_seen);
        reset = 1'b1;
        drive(1'b1, 32'h00225020, 1'b0, 1'b1, 5'd1, 32'd99, 1'b1); step("mrst", rdy_seen);
        check("mrst.valid", bus.out_valid, 1'b0);
        check("mrst.d1", bus.out_data1, 32'd0);
        reset = 1'b0;
        drive(1'b1, 32'h00225020, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1); step("post", rdy_seen);
        check("post.d1", bus.out_data1, 32'd0);
        check("post.d2", bus.out_data2, 32'd0);

        // Illegal opcode and illegal R-type function
        drive(1'b1, 32'hFC000000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1); step("ill", rdy_seen);
        check("ill.flag", bus.out_illegal, 1'b1);
        check("ill.rw", bus.out_reg_write, 1'b0);
        check("ill.dest", bus.out_dest, 5'd0);
        drive(1'b1, 32'h00221821, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1); step("illf", rdy_seen);
        check("illf.flag", bus.out_illegal, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            drive(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 3) != 0));
            step("rnd", rdy_seen);
        end
        reset = 1'b0;

        // NREG=8, XLEN=16: index aliasing and 16-bit immediate
        @(posedge clk); #1;
        reset8 = 1'b0;
        bus8.wb_en = 1'b1; bus8.wb_addr = 5'd9; bus8.wb_value = 16'h8001;
        @(posedge clk); #1;
        bus8.wb_en = 1'b0; bus8.in_valid = 1'b1; bus8.instruction = 32'h2022FFFF;
        @(posedge clk); #1;
        check("n8.valid", bus8.out_valid, 1'b1);
        check("n8.d1", bus8.out_data1, 16'h8001);
        check("n8.d2", bus8.out_data2, 16'hFFFF);
        check("n8.dest", bus8.out_dest, 5'd2);
        check("n8.rw", bus8.out_reg_write, 1'b1);
        bus8.instruction = 32'h00211820;
        bus8.wb_en = 1'b1; bus8.wb_addr = 5'd17; bus8.wb_value = 16'h1234;
        @(posedge clk); #1;
        check("n8byp.d1", bus8.out_data1, 16'h1234);
        check("n8byp.d2", bus8.out_data2, 16'h1234);
        bus8.in_valid = 1'b0; bus8.wb_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle MIPS decode stage.
- Decodes the R-type, addi, lw, sw and beq subset and reads a parametrised register file.
- Write-back to the register file arrives from a later stage through a dedicated write port.
- Captures operands and control into an ID/EX output register with valid/ready handshakes, write-back bypass, load-use stall insertion, flush and a stall counter.

Parameters:
XLEN, 32, datapath/register width in bits (>=16).
NREG, 32, number of architectural registers; power of 2, 2..32; register index = low log2(NREG) bits of the 5-bit field.
CNT_W, 16, width of the saturating stall counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
in_valid  input  1  instruction present
in_ready  output  1  instruction accepted when in_valid & in_ready at posedge
instruction  input  32  MIPS instruction word
flush  input  1  discard output register contents (branch redirect)
wb_en  input  1  register-file write enable
wb_addr  input  5  write index
wb_value  input  XLEN  write data
out_valid  output  1  output register holds a decoded instruction
out_ready  input  1  downstream accepts when out_valid & out_ready
out_data1  output  XLEN  rs operand
out_data2  output  XLEN  rt operand, or sign-extended imm for addi/lw/sw
out_store_data  output  XLEN  rt value (sw data)
out_dest  output  5  destination index (rd for R-type, rt for addi/lw, else 0)
out_aluop  output  4  add 0010, sub 0110, and 0000, or 0001, slt 0111
out_reg_write, out_mem_read, out_mem_write, out_branch, out_illegal  output  1 each  control flags
stall_count  output  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (sync, highest priority): all registers zero; out_valid=0; every out_* =0; stall_count=0. A write on wb_en in the reset cycle is dropped.
- load_en = !out_valid | out_ready.
- hazard = out_valid & out_mem_read & out_dest!=0 & (out_dest==rs | (uses_rt & out_dest==rt)). uses_rt is true for R-type, sw and beq.
- in_ready = load_en & !hazard & !flush (combinational).
- Posedge priority:
  - reset;
  - else flush: out_valid<=0;
  - else accept (in_valid & in_ready): output register loads the decoded instruction, out_valid<=1, giving 1-cycle latency;
  - else load_en & hazard: bubble, out_valid<=0, stall_count+1 saturating at all-ones, instruction not consumed;
  - else load_en: out_valid<=0;
  - else hold all outputs.
- Output fields are stable while out_valid & !out_ready.
- Register file:
  - Write at posedge when wb_en & wb_addr!=0.
  - Register 0 always reads 0.
  - Reads are combinational with bypass: if wb_en & wb_addr==index & index!=0, the read returns wb_value (same-cycle write-then-read).
- Decode:
  - R-type (opcode 000000) decodes func 100000/100010/100100/100101/101010.
  - addi, lw and sw use ALU add with imm sign-extended to XLEN. lw sets mem_read; sw sets mem_write.
  - beq uses sub and sets branch.
- Illegal: unknown opcode or R-type func forces out_illegal=1, reg_write/mem_read/mem_write/branch=0, aluop 0000, dest 0.
- out_reg_write=0 whenever out_dest==0.
- Simultaneous flush & hazard: flush wins, stall_count unchanged.
- Simultaneous accept & wb_en to a source register: bypassed value is captured.

Test Plan:
- Reset, then wb 5 to r1 and 7 to r2; send 0x00221820 (add r3,r1,r2) -> one cycle later out_valid=1, data1=5, data2=7, dest=3, aluop=0010, reg_write=1.
- Send 0x20010005 (addi r1,r0,5) with wb_en=1, wb_addr=0, wb_value=0xFFFF in the same cycle -> data1=0, data2=5, dest=1; r0 still reads 0 afterwards.
- Send 0x8C240008 (lw r4,8(r1)) then 0x00812820 (add r5,r4,r1) -> lw mem_read=1, data2=8; next cycle in_ready=0, out_valid=0, stall_count=1; add is accepted the following cycle.
- out_ready=0 for 3 cycles while holding a valid sub -> outputs unchanged, in_ready=0; release -> next instruction loads.
- Assert flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, in_ready=0 that cycle; assert reset mid-stream -> all outputs 0 and registers read 0.
- Send opcode 111111 -> out_illegal=1, reg_write=0, dest=0. Run with NREG=8, XLEN=16: wb 0x8001 to r9 writes r1, and addi imm 0xFFFF gives data2=0xFFFF.
